// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the digit-serial BCD adder/subtractor.
package bcd_pkg;
   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] BCD_MAX     = 4'd9;
   localparam logic [3:0] BCD_ADJ     = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;
endpackage

// File: rtl/bcd_digit_addsub.sv
// Combinational single-digit BCD add/subtract cell (nine's complement of b when sub=1).
module bcd_digit_addsub
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       sub,
   input  logic       cin,
   output logic [3:0] digit,
   output logic       cout,
   output logic       invalid
);

   logic [3:0] bd;
   logic [4:0] s;

   always_comb begin
      bd      = sub ? (BCD_MAX - b) : b;
      s       = {1'b0, a} + {1'b0, bd} + {4'b0000, cin};
      // Adding 6 modulo 16 skips the six unused codes and yields the decimal digit.
      if (s > {1'b0, BCD_MAX}) begin
         digit = s[3:0] + BCD_ADJ;
         cout  = 1'b1;
      end else begin
         digit = s[3:0];
         cout  = 1'b0;
      end
      invalid = (a > BCD_MAX) || (b > BCD_MAX);
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional feature: define BCD_INPUT_CHECK_EN to add the err port and invalid-digit check.
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
   input  logic                          sub,
   input  logic                          cin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] sum,
   output logic                          cout,
   output logic                          busy
`ifdef BCD_INPUT_CHECK_EN
   ,
   output logic                          err
`endif
);

   localparam int W    = BCD_DIGIT_W * DIGITS;
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DIGITS - 1);

   state_e          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [W-1:0]    work_q, work_d, sum_q, sum_d;
   logic [W-1:0]    work_shift;
   logic            sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;
   logic [3:0]      dig;
   logic            dig_cout;
   logic            err_q, err_d;

`ifdef BCD_INPUT_CHECK_EN
   logic dig_invalid;
`else
   logic dig_invalid_unused;
`endif

   bcd_digit_addsub u_digit (
      .a       (a_q[BCD_DIGIT_W-1:0]),
      .b       (b_q[BCD_DIGIT_W-1:0]),
      .sub     (sub_q),
      .cin     (carry_q),
      .digit   (dig),
      .cout    (dig_cout),
`ifdef BCD_INPUT_CHECK_EN
      .invalid (dig_invalid)
`else
      .invalid (dig_invalid_unused)
`endif
   );

   // New digits enter at the top so digit 0 lands at bits [3:0] after DIGITS shifts.
   generate
      if (DIGITS == 1) begin : g_one
         assign work_shift = dig;
      end else begin : g_many
         assign work_shift = {dig, work_q[W-1:BCD_DIGIT_W]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      sum_d   = sum_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sub_d   = sub;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               err_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> BCD_DIGIT_W;
            b_d     = b_q >> BCD_DIGIT_W;
            work_d  = work_shift;
            carry_d = dig_cout;
`ifdef BCD_INPUT_CHECK_EN
            err_d   = err_q | dig_invalid;
`endif
            if (idx_q == IDX_LAST) begin
               sum_d   = work_shift;
               cout_d  = dig_cout;
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         sum_q   <= sum_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef BCD_INPUT_CHECK_EN
   assign err       = err_q;
`endif

endmodule
